// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  // Busy vectors up to 256 entries are zero-extended into v before counting.
  function automatic int popcount_w(input logic [255:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 256; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback side bus of the register file: write, reserve and read ports.
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) ();

  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output we, waddr, wdata, rsv_en, rsv_addr, raddr,
    input  rdata, rbusy, busy_cnt
  );

  modport slave (
    input  we, waddr, wdata, rsv_en, rsv_addr, raddr,
    output rdata, rbusy, busy_cnt
  );

endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy bits plus a running count of busy registers.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [ADDR_W-1:0]    i_waddr,
  input  logic                 i_rsv_en,
  input  logic [ADDR_W-1:0]    i_rsv_addr,
  output logic [2**ADDR_W-1:0] o_busy,
  output logic [ADDR_W:0]      o_busy_cnt
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;
  logic [ADDR_W:0]  r_cnt;
  logic [ADDR_W:0]  w_cnt_next;
  logic             w_wr_act;
  logic             w_rsv_act;
  logic             w_set;
  logic             w_clr;

  assign w_wr_act  = i_we     && !((ZERO_REG != 0) && (i_waddr    == '0));
  assign w_rsv_act = i_rsv_en && !((ZERO_REG != 0) && (i_rsv_addr == '0));

  // A reserve on the register being written keeps it busy: the new producer wins.
  assign w_set = w_rsv_act && !r_busy[i_rsv_addr];
  assign w_clr = w_wr_act && r_busy[i_waddr] && !(w_rsv_act && (i_rsv_addr == i_waddr));

  always_comb begin
    w_busy_next = r_busy;
    if (w_wr_act) begin
      w_busy_next[i_waddr] = 1'b0;
    end
    if (w_rsv_act) begin
      w_busy_next[i_rsv_addr] = 1'b1;
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_set && !w_clr) begin
      w_cnt_next = r_cnt + 1'b1;
    end else if (w_clr && !w_set) begin
      w_cnt_next = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_next;
      r_cnt  <= w_cnt_next;
    end
  end

  assign o_busy     = r_busy;
  assign o_busy_cnt = r_cnt;

  a_cnt_matches_busy: assert property (
    @(posedge clk) disable iff (rst) popcount_w(256'(r_busy)) == int'(r_cnt)
  );

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with busy scoreboard and optional write-to-read forwarding.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  reg_file_mp_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]         w_busy;
  logic [NUM_RD*DATA_W-1:0] w_rdata;
  logic [NUM_RD-1:0]        w_rbusy;
  logic                     w_wr_act;

  assign w_wr_act = bus.we && !((ZERO_REG != 0) && (bus.waddr == '0));

  reg_file_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_we       (bus.we),
    .i_waddr    (bus.waddr),
    .i_rsv_en   (bus.rsv_en),
    .i_rsv_addr (bus.rsv_addr),
    .o_busy     (w_busy),
    .o_busy_cnt (bus.busy_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_act) begin
      r_mem[bus.waddr] <= bus.wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_zero;
      logic              w_byp;

      assign w_addr = bus.raddr[gi*ADDR_W +: ADDR_W];
      assign w_zero = (ZERO_REG != 0) && (w_addr == '0);
      assign w_byp  = (BYPASS != 0) && w_wr_act && (bus.waddr == w_addr);

      // Register 0 masking takes precedence over forwarding.
      assign w_rdata[gi*DATA_W +: DATA_W] = w_zero ? '0 :
                                            w_byp  ? bus.wdata : r_mem[w_addr];
      assign w_rbusy[gi] = !w_zero && !w_byp && w_busy[w_addr];
    end
  endgenerate

  assign bus.rdata = w_rdata;
  assign bus.rbusy = w_rbusy;

endmodule
